// File: rtl/onehot_mux_pkg.sv
// Shared constants and helpers for the one-hot channel selector.
// Vectors are zero-padded to MAX_IN so the helpers serve any channel count.
package onehot_mux_pkg;

  localparam int MODE_EXT_SEL = 0;
  localparam int MODE_RR      = 1;
  localparam int MAX_IN       = 32;

  function automatic logic is_onehot(input logic [MAX_IN-1:0] vec);
    return (vec != '0) && ((vec & (vec - 1'b1)) == '0);
  endfunction

  // One bit column of every channel, AND-ed with the select and OR-reduced.
  function automatic logic onehot_and_or(input logic [MAX_IN-1:0] data,
                                         input logic [MAX_IN-1:0] sel);
    return |(data & sel);
  endfunction

endpackage

// File: rtl/onehot_mux_rr_arbiter.sv
// Round-robin arbiter: the first requester at or after ptr wins.
// ptr moves one past the winner only when the grant is consumed (adv).
module rr_arbiter
  import onehot_mux_pkg::*;
#(
  parameter int IN_NUM = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IN_NUM-1:0] req,
  input  logic              adv,
  output logic [IN_NUM-1:0] gnt
);

  localparam int PW = $clog2(IN_NUM);

  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] win_idx;
  logic          found;
  int            idx;

  always_comb begin
    gnt     = '0;
    win_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int j = 0; j < IN_NUM; j++) begin
      idx = (int'(ptr_q) + j) % IN_NUM;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        win_idx  = PW'(idx);
        found    = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (adv) begin
      ptr_d = (win_idx == PW'(IN_NUM - 1)) ? '0 : win_idx + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/onehot_mux_rr.sv
// N-channel one-hot mux with a registered valid/ready output stage.
// Define ONEHOT_MUX_CHECK_EN to reject multi-hot grants and raise sticky err.
module onehot_mux_rr
  import onehot_mux_pkg::*;
#(
  parameter int IN_NUM = 4,
  parameter int BW     = 4,
  parameter int MODE   = MODE_EXT_SEL
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IN_NUM-1:0] s,
  input  logic [IN_NUM-1:0] in_valid,
  output logic [IN_NUM-1:0] in_ready,
  input  logic [BW-1:0]     i [IN_NUM],
  output logic              o_valid,
  input  logic              o_ready,
  output logic [BW-1:0]     o_out,
  output logic [IN_NUM-1:0] o_sel,
  output logic              err
);

  logic              ld;
  logic              xfer;
  logic [IN_NUM-1:0] raw_gnt;
  logic [IN_NUM-1:0] gnt;
  logic [MAX_IN-1:0] gnt_pad;
  logic [MAX_IN-1:0] col;
  logic [BW-1:0]     mux_data;

  logic              o_valid_q, o_valid_d;
  logic [BW-1:0]     o_out_q, o_out_d;
  logic [IN_NUM-1:0] o_sel_q, o_sel_d;

  assign ld = ~o_valid_q | o_ready;

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic unused_s;
      assign unused_s = ^s;
      rr_arbiter #(.IN_NUM(IN_NUM)) u_arb (
        .clk (clk),
        .rst (rst),
        .req (in_valid),
        .adv (xfer),
        .gnt (raw_gnt)
      );
    end else begin : g_ext
      assign raw_gnt = s;
    end
  endgenerate

`ifdef ONEHOT_MUX_CHECK_EN
  logic              err_q, err_d;
  logic              illegal;
  logic [MAX_IN-1:0] raw_pad;

  // A multi-hot grant is suppressed and latched into the sticky flag.
  always_comb begin
    raw_pad              = '0;
    raw_pad[IN_NUM-1:0]  = raw_gnt;
    illegal              = (raw_gnt != '0) && !is_onehot(raw_pad);
    gnt                  = illegal ? '0 : raw_gnt;
    err_d                = err_q | illegal;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

  assign err = err_q;
`else
  assign gnt = raw_gnt;
  assign err = 1'b0;
`endif

  // Multi-hot grants need every selected channel valid and OR their data.
  always_comb begin
    gnt_pad             = '0;
    gnt_pad[IN_NUM-1:0] = gnt;
    xfer     = ~rst & ld & (gnt != '0) & ((in_valid & gnt) == gnt);
    in_ready = rst ? '0 : (gnt & {IN_NUM{ld}});
    col      = '0;
    mux_data = '0;
    for (int b = 0; b < BW; b++) begin
      col = '0;
      for (int k = 0; k < IN_NUM; k++) col[k] = i[k][b];
      mux_data[b] = onehot_and_or(col, gnt_pad);
    end
  end

  always_comb begin
    o_valid_d = o_valid_q;
    o_out_d   = o_out_q;
    o_sel_d   = o_sel_q;
    if (ld) begin
      o_valid_d = xfer;
      if (xfer) begin
        o_out_d = mux_data;
        o_sel_d = gnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid_q <= 1'b0;
      o_out_q   <= '0;
      o_sel_q   <= '0;
    end else begin
      o_valid_q <= o_valid_d;
      o_out_q   <= o_out_d;
      o_sel_q   <= o_sel_d;
    end
  end

  assign o_valid = o_valid_q;
  assign o_out   = o_out_q;
  assign o_sel   = o_sel_q;

endmodule
